fetch_prefetch_queue: RTL
=========================

Name: fetch_prefetch_queue

Overview:
- Instruction-fetch front end that sits directly upstream of the IF/ID pipeline register.
- Generates sequential word addresses and issues in-order read requests to a latency-tolerant instruction memory port.
- Buffers returned words in a small FIFO and presents {instruction, PC+4} to the IF/ID register through a valid/ready handshake.
- Handles branch/jump redirects from the ID stage: flushes queued words and discards responses that are still in flight.

Parameters:
- DEPTH, 4: FIFO entries; also the maximum of queued plus outstanding requests. Power of two, 2..16.
- RESET_PC, 32'h0000_0000: fetch address after reset.

Ports:
- Clk  in  1  clock, rising edge.
- Rst  in  1  reset; asynchronous, active-low.
- ImReqValid  out  1  request to instruction memory.
- ImReqAddr  out  32  word-aligned request address.
- ImReqReady  in  1  memory accepts the request this cycle.
- ImRespValid  in  1  read data valid. Responses return in order, at least 1 cycle after acceptance, with no backpressure.
- ImRespData  in  32  instruction word.
- OutValid  out  1  head entry valid toward IF/ID.
- OutInstr  out  32  head instruction.
- OutPCAddResult  out  32  head PC+4.
- OutReady  in  1  IF/ID loads this cycle (deasserted on stall).
- Redirect  in  1  branch/jump taken in ID.
- RedirectPC  in  32  new fetch target; bits [1:0] ignored and forced to 00.

Behaviour:
- Reset (Rst=0, asynchronous):
  - fetch_pc = RESET_PC; FIFO empty; outstanding = 0; discard = 0; state FETCH.
  - Outputs: ImReqValid=0, ImReqAddr=RESET_PC, OutValid=0, OutInstr=0, OutPCAddResult=0.
  - Deassertion while memory has requests in flight is the integrator's responsibility; the block assumes the memory is reset together with it.
- Request issue:
  - ImReqValid = ~Redirect & (count + outstanding < DEPTH).
  - ImReqAddr = fetch_pc.
  - On ImReqValid & ImReqReady: fetch_pc += 4 (wraps modulo 2^32), outstanding += 1.
- Response:
  - On ImRespValid: outstanding -= 1.
  - If discard > 0 or Redirect: the word is dropped and discard -= 1 (when discard > 0).
  - Otherwise the word is pushed as {ImRespData, addr+4}. The address comes from a per-request PC tag FIFO of DEPTH entries.
  - Issue and response in the same cycle leave outstanding unchanged.
- Credit rule guarantees the FIFO never overflows on push. Overflow is an assertion failure.
- Output:
  - OutValid = (count != 0) & ~Redirect.
  - Pop on OutValid & OutReady.
  - Push and pop in the same cycle: count unchanged.
  - Latency from acceptance to OutValid = memory latency + 1 cycle (registered FIFO head).
- Redirect (single-cycle pulse, takes priority over every other event):
  - FIFO and PC-tag queue cleared; no pop occurs.
  - discard <= outstanding - ImRespValid.
  - fetch_pc <= {RedirectPC[31:2], 2'b00}; no request issued this cycle.
  - A redirect while in FLUSH reloads discard with the same formula.
- State machine:
  - FETCH: discard == 0.
  - FLUSH: discard > 0. Entered on a redirect with stale requests in flight; returns to FETCH when the last stale response arrives.
  - New requests may issue in FLUSH while credit allows. Stale entries count against credit.
- Widths:
  - count and outstanding are $clog2(DEPTH+1) bits.
  - Their sum never exceeds DEPTH.

Decomposition:
- Shared package fetch_pkg holds:
  - default DEPTH and RESET_PC;
  - NOP_INSTR = 32'h0000_0000;
  - state encoding FETCH=1'b0, FLUSH=1'b1.
- Sub-module fetch_fifo: synchronous FIFO, parameterised width/depth, with push/pop/clear, count, and empty/full. It is instantiated twice: one 64-bit instance for {instr, pc4} and one 32-bit instance as the request-address tag queue.

Test Plan:
- Reset: hold Rst=0 for 3 cycles, release with ImReqReady=1 → ImReqValid=1 and ImReqAddr=0x0 on the first cycle; OutValid=0 until the first response.
- Streaming: memory latency 1, OutReady=1, program words 0x20080005, 0x20090003 at 0x0 and 0x4 → OutInstr=0x20080005 with OutPCAddResult=0x4, then 0x20090003 with 0x8; one instruction per cycle sustained.
- Backpressure: OutReady=0, latency 2 → exactly 4 requests (0x0–0xC) accepted, then ImReqValid=0. Raise OutReady → 4 pops in order, after which requests resume at 0x10.
- Redirect with stale responses: 2 requests outstanding, Redirect=1 with RedirectPC=0x40 → both stale responses dropped; the next OutValid carries the word from 0x40 with OutPCAddResult=0x44.
- Simultaneous events: Redirect, ImRespValid and OutReady all high with count=2 → no pop, FIFO empty, discard = outstanding-1, OutValid=0 that cycle; RedirectPC=0x43 produces fetch 0x40.
- Wrap and mid-operation reset: RedirectPC=0xFFFFFFFC → fetches 0xFFFFFFFC then 0x00000000, and PC+4 reads 0x0. Asserting Rst mid-stream clears the outputs immediately without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch front-end types and defaults; no logic, no latency.
// Entry layout is {instr, pc4}, matching what the IF/ID register loads.
package fetch_pkg;

    localparam int          DEFAULT_DEPTH    = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

    typedef enum logic {
        FETCH = 1'b0,
        FLUSH = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with clear; a push shows at the head the next cycle.
// Pop is ignored when empty, and clear beats push/pop; pushing when full is an assertion failure.
module fetch_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [W-1:0]               push_dat,
    input  logic                       pop,
    input  logic                       clear,
    output logic [W-1:0]               head_dat,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign do_push  = push & ~clear;
    assign do_pop   = pop & ~clear & ~empty;
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: the head is never consumed while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clk) begin
        if (rst_n && do_push) assert (!full || do_pop);
    end

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Sequential instruction prefetch into a DEPTH-entry queue; acceptance to out_vld takes memory latency + 1.
// Requests are credit-limited by queued + outstanding; out_rdy low stalls the queue; a redirect flushes it and drops stale responses.
module fetch_prefetch_queue
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = DEFAULT_DEPTH,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        im_req_vld,
    output logic [31:0] im_req_addr,
    input  logic        im_req_rdy,
    input  logic        im_resp_vld,
    input  logic [31:0] im_resp_dat,
    output logic        out_vld,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc_add_result,
    input  logic        out_rdy,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int CW = $clog2(DEPTH+1);

    fetch_state_t  state;
    logic [31:0]   fetch_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] outstanding_nxt;
    logic [CW-1:0] discard;
    logic [CW-1:0] discard_nxt;
    logic [CW:0]   credit_used;

    logic          issue;
    logic          drop;
    logic          push;
    logic          pop;

    fetch_entry_t  push_entry;
    fetch_entry_t  head;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;

    logic [31:0]   tag_head;
    logic [CW-1:0] tag_count;
    logic          tag_empty;
    logic          tag_full;

    // Stale entries still in flight consume credit, so the queue can absorb every response.
    assign credit_used = {1'b0, count} + {1'b0, outstanding};
    assign im_req_vld  = rst_n & ~redirect & (credit_used < (CW+1)'(DEPTH));
    assign im_req_addr = fetch_pc;
    assign issue       = im_req_vld & im_req_rdy;

    assign drop       = im_resp_vld & (redirect | (state == FLUSH));
    assign push       = im_resp_vld & ~drop;
    assign push_entry = '{instr: im_resp_dat, pc4: tag_head + 32'd4};

    assign out_vld           = ~empty & ~redirect;
    assign pop               = out_vld & out_rdy;
    assign out_instr         = empty ? NOP_INSTR : head.instr;
    assign out_pc_add_result = empty ? 32'd0 : head.pc4;

    always_comb begin
        outstanding_nxt = outstanding + CW'(issue) - CW'(im_resp_vld);
        discard_nxt     = discard;
        if (redirect)
            discard_nxt = outstanding_nxt;
        else if (im_resp_vld && state == FLUSH)
            discard_nxt = discard - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            state       <= FETCH;
        end else begin
            if (redirect)
                fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
            else if (issue)
                fetch_pc <= fetch_pc + 32'd4;
            outstanding <= outstanding_nxt;
            discard     <= discard_nxt;
            state       <= (discard_nxt != '0) ? FLUSH : FETCH;
        end
    end

    fetch_fifo #(
        .W     ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_data_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat (push_entry),
        .pop      (pop),
        .clear    (redirect),
        .head_dat (head),
        .count    (count),
        .empty    (empty),
        .full     (full)
    );

    // One tag per live request; stale tags vanish with the redirect clear.
    fetch_fifo #(
        .W     (32),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (issue),
        .push_dat (fetch_pc),
        .pop      (push),
        .clear    (redirect),
        .head_dat (tag_head),
        .count    (tag_count),
        .empty    (tag_empty),
        .full     (tag_full)
    );

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(push && full && !pop));
            assert (!(push && tag_empty));
            assert (!(issue && tag_full));
            assert (!(im_resp_vld && outstanding == '0));
            assert (credit_used <= (CW+1)'(DEPTH));
            assert (tag_count <= outstanding);
        end
    end

endmodule
